// File: rtl/alu_control_pipe.sv
// ---------------------------------------------------------------------------
// alu_control_pipe
//
// Pipelined ALU control unit for the MIPS datapath. Decodes the ALU opcode
// from main control (or, for R-type, the funct field) into the 4-bit ALU
// control code and delivers it through STAGES register stages. A MULA op
// holds the unit for MULA_CYCLES cycles by dropping o_InReady, and a flush
// from the hazard unit squashes everything in flight.
//
// Parameters
//   STAGES       register stages from acceptance to o_ALUCtrl (1..4)
//   MULA_CYCLES  total cycles a MULA occupies the unit (1..15)
//
// Ports
//   i_CLK        clock, rising edge
//   i_Reset      synchronous, active-high reset
//   i_Flush      squash in-flight entries and any MULA sequence
//   i_InValid    i_ALUop / i_FuncCode valid this cycle
//   o_InReady    unit can accept this cycle (from state only)
//   i_ALUop      ALU opcode from control; 4'b1111 selects R-type decode
//   i_FuncCode   instruction funct field, used only for R-type
//   o_ALUCtrl    registered ALU control code, holds when o_OutValid = 0
//   o_OutValid   o_ALUCtrl valid this cycle
//   o_Busy       MULA sequence in progress
//   o_Illegal    unknown R-type funct (only with ALUCTRL_ILLEGAL_TRAP_EN)
//
// Optional feature macro: ALUCTRL_ILLEGAL_TRAP_EN
//   When defined, the o_Illegal port exists and is pipelined with o_ALUCtrl.
//   When undefined, unknown functs silently decode to AND.
// ---------------------------------------------------------------------------
module alu_control_pipe #(
   parameter int STAGES      = 1,
   parameter int MULA_CYCLES = 3
) (
   input  logic       i_CLK,
   input  logic       i_Reset,
   input  logic       i_Flush,
   input  logic       i_InValid,
   output logic       o_InReady,
   input  logic [3:0] i_ALUop,
   input  logic [5:0] i_FuncCode,
   output logic [3:0] o_ALUCtrl,
   output logic       o_OutValid,
`ifdef ALUCTRL_ILLEGAL_TRAP_EN
   output logic       o_Illegal,
`endif
   output logic       o_Busy
);

   typedef enum logic [3:0] {
      C_AND  = 4'h0, C_OR   = 4'h1, C_ADD  = 4'h2, C_SLL  = 4'h3,
      C_SRL  = 4'h4, C_MULA = 4'h5, C_SUB  = 4'h6, C_SLT  = 4'h7,
      C_ADDU = 4'h8, C_SUBU = 4'h9, C_XOR  = 4'hA, C_SLTU = 4'hB,
      C_NOR  = 4'hC, C_SRA  = 4'hD, C_LUI  = 4'hE
   } alu_ctrl_e;

   typedef enum logic {
      IDLE  = 1'b0,
      MULTI = 1'b1
   } state_e;

   localparam logic [3:0] RTYPE_OP = 4'hF;
   localparam logic [3:0] MULA_LOAD = 4'(MULA_CYCLES - 1);

   // ---------------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------------
   logic [3:0] w_code;
   logic       w_unknown;

   // NOTE: every output of a combinational block gets a default first, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_code    = i_ALUop;
      w_unknown = 1'b0;
      // The funct field is examined only for R-type, so an X/Z funct on an
      // immediate op never reaches the result.
      if (i_ALUop == RTYPE_OP) begin
         unique case (i_FuncCode)
            6'b000000: w_code = C_SLL;
            6'b000010: w_code = C_SRL;
            6'b000011: w_code = C_SRA;
            6'b100000: w_code = C_ADD;
            6'b100001: w_code = C_ADDU;
            6'b100010: w_code = C_SUB;
            6'b100011: w_code = C_SUBU;
            6'b100100: w_code = C_AND;
            6'b100101: w_code = C_OR;
            6'b100110: w_code = C_XOR;
            6'b100111: w_code = C_NOR;
            6'b101010: w_code = C_SLT;
            6'b101011: w_code = C_SLTU;
            6'b111000: w_code = C_MULA;
            default: begin
               w_code    = C_AND;
               w_unknown = 1'b1;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // MULA sequencing FSM
   // ---------------------------------------------------------------------
   state_e     r_state;
   state_e     w_state_nxt;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nxt;
   logic       w_accept;

   assign o_InReady = (r_state == IDLE);
   assign o_Busy    = (r_state == MULTI);
   // Flush outranks acceptance: an input presented alongside it is dropped.
   assign w_accept  = i_InValid && o_InReady && !i_Flush;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (i_Flush) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = 4'd0;
      end else begin
         unique case (r_state)
            IDLE: begin
               // A single-cycle MULA configuration never leaves IDLE.
               if (w_accept && (w_code == C_MULA) && (MULA_CYCLES > 1)) begin
                  w_state_nxt = MULTI;
                  w_cnt_nxt   = MULA_LOAD;
               end
            end
            MULTI: begin
               w_cnt_nxt = r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  w_state_nxt = IDLE;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = 4'd0;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge i_CLK) begin
      if (i_Reset) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Result pipeline: a STAGES-deep shift of {valid, code}
   // ---------------------------------------------------------------------
   logic [STAGES-1:0] r_vld;
   logic [3:0]        r_code [STAGES];
`ifdef ALUCTRL_ILLEGAL_TRAP_EN
   logic [STAGES-1:0] r_ill;
`endif

   // NOTE: the code registers are a handful of pipeline flops, not a memory
   // array, so they are reset too; that gives o_ALUCtrl = 0 after reset.
   always_ff @(posedge i_CLK) begin
      if (i_Reset) begin
         r_vld  <= '0;
         r_code <= '{default: 4'd0};
`ifdef ALUCTRL_ILLEGAL_TRAP_EN
         r_ill  <= '0;
`endif
      end else if (i_Flush) begin
         // Codes are left untouched so o_ALUCtrl keeps its last value.
         r_vld <= '0;
      end else begin
         r_vld[0] <= w_accept;
         if (w_accept) begin
            r_code[0] <= w_code;
`ifdef ALUCTRL_ILLEGAL_TRAP_EN
            r_ill[0]  <= w_unknown;
`endif
         end
         for (int i = 1; i < STAGES; i++) begin
            r_vld[i] <= r_vld[i-1];
            // Codes advance only behind a valid entry; bubbles leave them
            // alone so the output holds between results.
            if (r_vld[i-1]) begin
               r_code[i] <= r_code[i-1];
`ifdef ALUCTRL_ILLEGAL_TRAP_EN
               r_ill[i]  <= r_ill[i-1];
`endif
            end
         end
      end
   end

   assign o_ALUCtrl  = r_code[STAGES-1];
   assign o_OutValid = r_vld[STAGES-1];

`ifdef ALUCTRL_ILLEGAL_TRAP_EN
   assign o_Illegal = r_vld[STAGES-1] & r_ill[STAGES-1];
`else
   // Without the trap, the unknown-funct flag has no consumer.
   logic w_unknown_unused;
   assign w_unknown_unused = w_unknown;
`endif

endmodule
